mem_bus_arbiter: RTL and testbench

Arbitrates the single memory bus between the instruction cache and the data cache, and routes each returned load tag back to the cache that issued it. Sits between the core's cache controllers and the memory model. It replaces the combinational "dcache-wins" mux with fair arbitration and per-tag ownership tracking. Requests pass through in the same cycle; ownership and fairness state are registered.

---
 rtl/mem_bus_arbiter.sv | 87 ++++++++
 tb/tb_mem_bus_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: fair icache/dcache memory-bus arbiter with per-tag return routing
module mem_bus_arbiter #(
  parameter int XLEN = 32,
  parameter int TAG_W = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       icache2arb_command,
  input  logic [XLEN-1:0]  icache2arb_addr,
  input  logic [1:0]       dcache2arb_command,
  input  logic [XLEN-1:0]  dcache2arb_addr,
  input  logic [63:0]      dcache2arb_data,
  output logic [1:0]       arb2mem_command,
  output logic [XLEN-1:0]  arb2mem_addr,
  output logic [63:0]      arb2mem_data,
  input  logic [TAG_W-1:0] mem2arb_response,
  input  logic [63:0]      mem2arb_data,
  input  logic [TAG_W-1:0] mem2arb_tag,
  output logic [TAG_W-1:0] arb2icache_response,
  output logic [TAG_W-1:0] arb2dcache_response,
  output logic [63:0]      arb2icache_data,
  output logic [63:0]      arb2dcache_data,
  output logic [TAG_W-1:0] arb2icache_tag,
  output logic [TAG_W-1:0] arb2dcache_tag,
  output logic [TAG_W:0]   outstanding,
  output logic             orphan_tag_err
);
  localparam int N = 1 << TAG_W;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  logic [N-1:0] valid_q, valid_d, src_q, src_d;
  logic [SW-1:0] starve_q, starve_d;
  logic orphan_q, orphan_d;
  logic [TAG_W:0] outstanding_q, outstanding_d;
  logic i_req, d_req, grant_i, grant_d, ret_hit, ret_d, tag_nz;
  logic [1:0] mem_cmd;
  always_comb begin
    i_req = icache2arb_command != BUS_NONE;
    d_req = dcache2arb_command != BUS_NONE;
    grant_i = i_req && (!d_req || starve_q == SW'(STARVE_LIMIT));
    grant_d = d_req && !grant_i;
    mem_cmd = grant_i ? icache2arb_command : grant_d ? dcache2arb_command : BUS_NONE;
    tag_nz = mem2arb_tag != '0;
    ret_hit = tag_nz && valid_q[mem2arb_tag];
    ret_d = src_q[mem2arb_tag];
    arb2mem_command = reset ? mem_cmd : BUS_NONE;
    arb2mem_addr = grant_i ? icache2arb_addr : dcache2arb_addr;
    arb2mem_data = dcache2arb_data;
    arb2icache_response = (reset && grant_i) ? mem2arb_response : '0;
    arb2dcache_response = (reset && grant_d) ? mem2arb_response : '0;
    arb2icache_tag = (reset && ret_hit && !ret_d) ? mem2arb_tag : '0;
    arb2dcache_tag = (reset && ret_hit && ret_d) ? mem2arb_tag : '0;
    arb2icache_data = (reset && ret_hit && !ret_d) ? mem2arb_data : '0;
    arb2dcache_data = (reset && ret_hit && ret_d) ? mem2arb_data : '0;
    outstanding = reset ? outstanding_q : '0;
    orphan_tag_err = orphan_q;
    // return clears before acceptance sets, so a reused tag ends owned by the new requester
    valid_d = valid_q;
    src_d = src_q;
    if (ret_hit) valid_d[mem2arb_tag] = 1'b0;
    if (mem_cmd == BUS_LOAD && mem2arb_response != '0) begin
      valid_d[mem2arb_response] = 1'b1;
      src_d[mem2arb_response] = grant_d;
    end
    starve_d = (i_req && !grant_i) ? starve_q + SW'(1) : '0;
    orphan_d = orphan_q || (tag_nz && !valid_q[mem2arb_tag]);
    outstanding_d = '0;
    for (int i = 0; i < N; i++) outstanding_d = outstanding_d + (TAG_W+1)'(valid_d[i]);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      src_q <= '0;
      starve_q <= '0;
      orphan_q <= 1'b0;
      outstanding_q <= '0;
    end else begin
      valid_q <= valid_d;
      src_q <= src_d;
      starve_q <= starve_d;
      orphan_q <= orphan_d;
      outstanding_q <= outstanding_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic [1:0] ic_cmd, dc_cmd, mem_cmd;
  logic [31:0] ic_addr, dc_addr, mem_addr;
  logic [63:0] dc_data, mem_wdata, m_data, ic_data, dc_rdata;
  logic [3:0] m_resp, m_tag, ic_resp, dc_resp, ic_tag, dc_tag;
  logic [4:0] outstanding;
  logic orphan;
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .icache2arb_command(ic_cmd), .icache2arb_addr(ic_addr),
    .dcache2arb_command(dc_cmd), .dcache2arb_addr(dc_addr), .dcache2arb_data(dc_data),
    .arb2mem_command(mem_cmd), .arb2mem_addr(mem_addr), .arb2mem_data(mem_wdata),
    .mem2arb_response(m_resp), .mem2arb_data(m_data), .mem2arb_tag(m_tag),
    .arb2icache_response(ic_resp), .arb2dcache_response(dc_resp),
    .arb2icache_data(ic_data), .arb2dcache_data(dc_rdata),
    .arb2icache_tag(ic_tag), .arb2dcache_tag(dc_tag),
    .outstanding(outstanding), .orphan_tag_err(orphan)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ic_cmd = 2'd0; ic_addr = '0; dc_cmd = 2'd0; dc_addr = '0; dc_data = '0;
    m_resp = '0; m_tag = '0; m_data = '0;
  endtask

  // advance one edge, then leave inputs idle just after it
  task automatic tick();
    @(posedge clock);
    #1 idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    ic_cmd = 2'd1; ic_addr = 32'h100; m_resp = 4'd3;
    #1;
    chk("rst_cmd", mem_cmd, 0);
    chk("rst_icresp", ic_resp, 0);
    tick();
    chk("rst_outst", outstanding, 0);
    chk("rst_orphan", orphan, 0);
    reset = 1'b1;
    // icache load alone, then its return
    ic_cmd = 2'd1; ic_addr = 32'h100; m_resp = 4'd3;
    #1;
    chk("t1_cmd", mem_cmd, 1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_icresp", ic_resp, 3);
    chk("t1_dcresp", dc_resp, 0);
    tick();
    chk("t1_outst1", outstanding, 1);
    m_tag = 4'd3; m_data = 64'hDEAD;
    #1;
    chk("t1_ictag", ic_tag, 3);
    chk("t1_icdata", ic_data, 64'hDEAD);
    chk("t1_dctag", dc_tag, 0);
    chk("t1_dcdata", dc_rdata, 0);
    tick();
    chk("t1_outst0", outstanding, 0);
    chk("t1_orphan", orphan, 0);
    // both request continuously: icache wins cycles 4 and 9
    for (int k = 0; k < 11; k++) begin
      ic_cmd = 2'd1; ic_addr = 32'h111; dc_cmd = 2'd1; dc_addr = 32'h222;
      #1;
      chk($sformatf("starve_c%0d", k), mem_addr, (k == 4 || k == 9) ? 32'h111 : 32'h222);
      tick();
    end
    // store is forwarded but not tracked; its tag returns as an orphan
    dc_cmd = 2'd2; dc_addr = 32'h200; dc_data = 64'h1234_5678_9ABC_DEF0; m_resp = 4'd5;
    #1;
    chk("st_cmd", mem_cmd, 2);
    chk("st_addr", mem_addr, 32'h200);
    chk("st_data", mem_wdata, 64'h1234_5678_9ABC_DEF0);
    chk("st_dcresp", dc_resp, 5);
    chk("st_icresp", ic_resp, 0);
    tick();
    chk("st_outst", outstanding, 0);
    m_tag = 4'd5; m_data = 64'h55;
    #1;
    chk("st_ictag", ic_tag, 0);
    chk("st_dctag", dc_tag, 0);
    chk("st_dcdata", dc_rdata, 0);
    tick();
    chk("st_orphan", orphan, 1);
    // tag 7 returns to icache while being reallocated to dcache
    ic_cmd = 2'd1; ic_addr = 32'h300; m_resp = 4'd7;
    tick();
    chk("re_outst1", outstanding, 1);
    dc_cmd = 2'd1; dc_addr = 32'h400; m_resp = 4'd7; m_tag = 4'd7; m_data = 64'hBEEF;
    #1;
    chk("re_dcresp", dc_resp, 7);
    chk("re_ictag", ic_tag, 7);
    chk("re_icdata", ic_data, 64'hBEEF);
    chk("re_dctag", dc_tag, 0);
    tick();
    chk("re_outst2", outstanding, 1);
    m_tag = 4'd7; m_data = 64'hCAFE;
    #1;
    chk("re2_dctag", dc_tag, 7);
    chk("re2_dcdata", dc_rdata, 64'hCAFE);
    chk("re2_ictag", ic_tag, 0);
    tick();
    chk("re2_outst", outstanding, 0);
    // three loads outstanding, then reset mid-operation
    ic_cmd = 2'd1; ic_addr = 32'h10; m_resp = 4'd1;
    tick();
    dc_cmd = 2'd1; dc_addr = 32'h20; m_resp = 4'd2;
    tick();
    ic_cmd = 2'd1; ic_addr = 32'h30; m_resp = 4'd4;
    tick();
    chk("mr_outst3", outstanding, 3);
    reset = 1'b0;
    dc_cmd = 2'd1; dc_addr = 32'h40; m_resp = 4'd6;
    #1;
    chk("mr_cmd", mem_cmd, 0);
    chk("mr_dcresp", dc_resp, 0);
    chk("mr_outst_lo", outstanding, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("mr_outst", outstanding, 0);
    chk("mr_orphan0", orphan, 0);
    m_tag = 4'd2; m_data = 64'h77;
    #1;
    chk("mr_dctag", dc_tag, 0);
    chk("mr_ictag", ic_tag, 0);
    tick();
    chk("mr_orphan1", orphan, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
